// File: rtl/swan_theta_seq.sv
// SWAN theta diffusion sequencer: one shared 32-bit vartheta stage,
// applied to the left then right half of a 64-bit block per round.
//
// Ports (swan_theta_seq):
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       input block handshake
//   in_data, in_rounds      block ([0] = MSB) and round count
//   out_valid/out_ready     result handshake
//   out_data                result block (mirrors internal blk)
//   busy                    high whenever not IDLE
//
// Ports (vartheta):
//   x_i                     32-bit half-block in, [0] = MSB
//   y_o                     diffused half-block out

`timescale 1ns/1ps

module vartheta (
    input  logic [0:31] x_i,
    output logic [0:31] y_o
);

    // Byte-wise left rotations by 1, 6, 7 and 0 (byte 0 = MSB byte).
    assign y_o = {x_i[1:7],   x_i[0],
                  x_i[14:15], x_i[8:13],
                  x_i[23],    x_i[16:22],
                  x_i[24:31]};

endmodule

module swan_theta_seq #(
    parameter int BLOCK_SIZE = 64,
    parameter int SIDE_SIZE  = BLOCK_SIZE / 2,
    parameter int ROUNDS_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [0:BLOCK_SIZE-1] in_data,
    input  logic [ROUNDS_W-1:0]   in_rounds,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [0:BLOCK_SIZE-1] out_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        LEFT,
        RIGHT,
        DONE
    } state_t;

    state_t                  state_q;
    logic [0:BLOCK_SIZE-1]   blk_q;
    logic [ROUNDS_W-1:0]     cnt_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    busy_q;

    logic [0:SIDE_SIZE-1]    theta_in;
    logic [0:SIDE_SIZE-1]    theta_out;

    // Single shared stage; mux picks the half being worked on.
    assign theta_in = (state_q == RIGHT) ? blk_q[SIDE_SIZE:BLOCK_SIZE-1]
                                         : blk_q[0:SIDE_SIZE-1];

    vartheta u_theta (
        .x_i (theta_in),
        .y_o (theta_out)
    );

    // Handshake flags are registered alongside the state so they
    // are pure state decodes with no input-to-output path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            blk_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        blk_q      <= in_data;
                        cnt_q      <= in_rounds;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (in_rounds == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= LEFT;
                        end
                    end
                end
                LEFT: begin
                    blk_q[0:SIDE_SIZE-1] <= theta_out;
                    state_q              <= RIGHT;
                end
                RIGHT: begin
                    blk_q[SIDE_SIZE:BLOCK_SIZE-1] <= theta_out;
                    // Only reached with cnt_q >= 1, so no wrap.
                    cnt_q <= cnt_q - {{(ROUNDS_W-1){1'b0}}, 1'b1};
                    if (cnt_q == {{(ROUNDS_W-1){1'b0}}, 1'b1}) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q <= LEFT;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = blk_q;

endmodule

// File: tb/tb_swan_theta_seq.sv
// Directed testbench for swan_theta_seq.
// Expected blocks are hand-computed byte rotations of the inputs.

`timescale 1ns/1ps

module tb_swan_theta_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [0:63] in_data;
    logic [3:0]  in_rounds;
    logic        out_valid;
    logic        out_ready;
    logic [0:63] out_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    localparam logic [0:63] BLK_A  = 64'h78563412_78563412;
    localparam logic [0:63] BLK_A1 = 64'hf0951a12_f0951a12;
    localparam logic [0:63] BLK_C  = 64'h01234567_89abcdef;
    localparam logic [0:63] BLK_C15 = 64'h808c8a67_c4ae9bef;
    localparam logic [0:63] BLK_B  = 64'h78563412_01234567;
    localparam logic [0:63] BLK_B2 = 64'he1650d12_04325167;

    swan_theta_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_rounds (in_rounds),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a block and return #1 after the accepting edge.
    task automatic accept_block(input logic [0:63] d,
                                input logic [3:0] r);
        int n;
        n = 0;
        @(negedge clk);
        in_data   = d;
        in_rounds = r;
        in_valid  = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Edges counted from the accept edge (which is edge 1).
    task automatic wait_valid(output int e);
        e = 1;
        while (!out_valid && e < 64) begin
            @(posedge clk);
            #1;
            e++;
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got v=%b b=%b want 0 0",
                     out_valid, busy);
        end
        checks++;
        if (out_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", out_data);
        end
    endtask

    task automatic test_one_round();
        int e;
        accept_block(BLK_A, 4'd1);
        wait_valid(e);
        checks++;
        if (e !== 3) begin
            errors++;
            $display("FAIL r1_latency got %0d want 3", e);
        end
        checks++;
        if (out_data !== BLK_A1) begin
            errors++;
            $display("FAIL r1_data got %h want %h", out_data, BLK_A1);
        end
        handshake();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL r1_after_hs got r=%b v=%b want 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_zero_rounds();
        int e;
        accept_block(BLK_C, 4'd0);
        wait_valid(e);
        checks++;
        if (e !== 1) begin
            errors++;
            $display("FAIL r0_latency got %0d want 1", e);
        end
        checks++;
        if (out_data !== BLK_C || busy !== 1'b1) begin
            errors++;
            $display("FAIL r0_done got %h b=%b want %h 1",
                     out_data, busy, BLK_C);
        end
        handshake();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL r0_busy_after got %b want 0", busy);
        end
    endtask

    task automatic test_max_rounds();
        int e;
        logic saw_ready;
        accept_block(BLK_C, 4'd15);
        e = 1;
        saw_ready = in_ready;
        while (!out_valid && e < 64) begin
            @(posedge clk);
            #1;
            e++;
            saw_ready = saw_ready | in_ready;
        end
        checks++;
        if (e !== 31) begin
            errors++;
            $display("FAIL r15_latency got %0d want 31", e);
        end
        checks++;
        if (saw_ready !== 1'b0) begin
            errors++;
            $display("FAIL r15_in_ready got %b want 0", saw_ready);
        end
        checks++;
        if (out_data !== BLK_C15) begin
            errors++;
            $display("FAIL r15_data got %h want %h", out_data, BLK_C15);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int e;
        accept_block(BLK_A, 4'd1);
        in_data  = BLK_C;
        in_valid = 1'b1;
        wait_valid(e);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== BLK_A1 ||
                in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b r=%b %h want 1 0 %h",
                         i, out_valid, in_ready, out_data, BLK_A1);
            end
        end
        in_valid = 1'b0;
        handshake();
        checks++;
        if (busy !== 1'b0 || out_data !== BLK_A1) begin
            errors++;
            $display("FAIL bp_release got b=%b %h want 0 %h",
                     busy, out_data, BLK_A1);
        end
    endtask

    task automatic test_reset_mid();
        int e;
        accept_block(BLK_C, 4'd3);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
            busy !== 1'b0 || out_data !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset got r=%b v=%b b=%b %h want 1 0 0 0",
                     in_ready, out_valid, busy, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        accept_block(BLK_A, 4'd1);
        wait_valid(e);
        checks++;
        if (e !== 3 || out_data !== BLK_A1) begin
            errors++;
            $display("FAIL post_reset got e=%0d %h want 3 %h",
                     e, out_data, BLK_A1);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int idx, acc1, acc2, nres;
        int hs_idx [2];
        logic [0:63] res [2];
        logic a, h;
        logic [0:63] d;
        idx = 0;
        acc1 = -1;
        acc2 = -1;
        nres = 0;
        hs_idx[0] = -1;
        hs_idx[1] = -1;
        res[0] = '0;
        res[1] = '0;
        @(negedge clk);
        in_data   = BLK_A;
        in_rounds = 4'd1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            a = in_valid & in_ready;
            h = out_valid & out_ready;
            d = out_data;
            @(posedge clk);
            idx++;
            if (a) begin
                if (acc1 < 0) acc1 = idx;
                else if (acc2 < 0) acc2 = idx;
            end
            if (h && nres < 2) begin
                res[nres] = d;
                hs_idx[nres] = idx;
                nres++;
            end
            #1;
            if (acc2 > 0) begin
                in_valid = 1'b0;
            end else if (acc1 > 0) begin
                in_data   = BLK_B;
                in_rounds = 4'd2;
            end
            if (nres == 2) break;
            @(negedge clk);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (hs_idx[0] !== acc1 + 3) begin
            errors++;
            $display("FAIL b2b_hs1 got %0d want %0d",
                     hs_idx[0], acc1 + 3);
        end
        checks++;
        if (acc2 !== hs_idx[0] + 1) begin
            errors++;
            $display("FAIL b2b_accept2 got %0d want %0d",
                     acc2, hs_idx[0] + 1);
        end
        checks++;
        if (res[0] !== BLK_A1 || res[1] !== BLK_B2) begin
            errors++;
            $display("FAIL b2b_order got %h %h want %h %h",
                     res[0], res[1], BLK_A1, BLK_B2);
        end
        checks++;
        if (hs_idx[1] !== acc2 + 5) begin
            errors++;
            $display("FAIL b2b_hs2 got %0d want %0d",
                     hs_idx[1], acc2 + 5);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_rounds = '0;
        out_ready = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_one_round();
        test_zero_rounds();
        test_max_rounds();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
